// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package reg_file_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;

  // popcount operand is zero-padded to this width; covers ADDR_W up to 10
  localparam int unsigned POP_MAX_W = 1024;
  localparam int unsigned POP_CNT_W = 11;

  function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] vec);
    logic [POP_CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + POP_CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_file_mp_sb.sv
// Pending-bit scoreboard: reserve sets, write clears, flush clears all,
// registered population count of pending bits.
module reg_file_mp_sb
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int          ZERO_REG = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr0_en_i,
  input  logic [ADDR_W-1:0]    wr0_addr_i,
  input  logic                 wr1_en_i,
  input  logic [ADDR_W-1:0]    wr1_addr_i,
  input  logic                 rsv_en_i,
  input  logic [ADDR_W-1:0]    rsv_addr_i,
  input  logic                 flush_i,
  output logic [2**ADDR_W-1:0] pend_o,
  output logic [ADDR_W:0]      pend_cnt_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]     pend_q, pend_d;
  logic [ADDR_W:0]      cnt_q, cnt_d;
  logic [POP_MAX_W-1:0] pop_vec;
  logic [POP_CNT_W-1:0] pop_cnt;

  // Next pending vector: writes clear, reserve then sets, flush overrides all.
  always_comb begin
    pend_d = pend_q;
    if (wr0_en_i) pend_d[wr0_addr_i] = 1'b0;
    if (wr1_en_i) pend_d[wr1_addr_i] = 1'b0;
    if (rsv_en_i) pend_d[rsv_addr_i] = 1'b1;
    if (flush_i)  pend_d = '0;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
    pop_vec = '0;
    pop_vec[DEPTH-1:0] = pend_d;
    pop_cnt = popcount(pop_vec);
    cnt_d   = pop_cnt[ADDR_W:0];
  end

  // Pending state and its count, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read
// ports, per-register pending scoreboard.
// Optional macro REG_FILE_MP_BYPASS_EN forwards same-cycle write data
// (port 1 over port 0) to matching read ports.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int          ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr0_en_i,
  input  logic [ADDR_W-1:0]        wr0_addr_i,
  input  logic [DATA_W-1:0]        wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [ADDR_W-1:0]        wr1_addr_i,
  input  logic [DATA_W-1:0]        wr1_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  input  logic                     flush_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pend_o,
  output logic [ADDR_W:0]          pend_cnt_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [ADDR_W-1:0] ra;
  logic              wr0_ok, wr1_ok;

  assign wr0_ok = wr0_en_i && !((ZERO_REG != 0) && (wr0_addr_i == '0));
  assign wr1_ok = wr1_en_i && !((ZERO_REG != 0) && (wr1_addr_i == '0));

  reg_file_mp_sb #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr0_en_i   (wr0_en_i),
    .wr0_addr_i (wr0_addr_i),
    .wr1_en_i   (wr1_en_i),
    .wr1_addr_i (wr1_addr_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .flush_i    (flush_i),
    .pend_o     (pend_q),
    .pend_cnt_o (pend_cnt_o)
  );

  // Next array contents; port 1 applied last so it wins on address collision.
  always_comb begin
    mem_d = mem_q;
    if (wr0_ok) mem_d[wr0_addr_i] = wr0_data_i;
    if (wr1_ok) mem_d[wr1_addr_i] = wr1_data_i;
  end

  // Data array, synchronous active-low reset clears every register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // Read muxes: stored value/pending, optional bypass, zero register forced last.
  always_comb begin
    rd_data_o = '0;
    rd_pend_o = '0;
    ra        = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = rd_addr_i[k*ADDR_W +: ADDR_W];
      rd_data_o[k*DATA_W +: DATA_W] = mem_q[ra];
      rd_pend_o[k]                  = pend_q[ra];
`ifdef REG_FILE_MP_BYPASS_EN
      if (wr0_en_i && (wr0_addr_i == ra)) begin
        rd_data_o[k*DATA_W +: DATA_W] = wr0_data_i;
        rd_pend_o[k]                  = rsv_en_i && (rsv_addr_i == ra);
      end
      if (wr1_en_i && (wr1_addr_i == ra)) begin
        rd_data_o[k*DATA_W +: DATA_W] = wr1_data_i;
        rd_pend_o[k]                  = rsv_en_i && (rsv_addr_i == ra);
      end
`else
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
        rd_pend_o[k]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default parameters).
module tb_reg_file_mp;

`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr0_en_i, wr1_en_i, rsv_en_i, flush_i;
  logic [4:0]  wr0_addr_i, wr1_addr_i, rsv_addr_i;
  logic [31:0] wr0_data_i, wr1_data_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_pend_o;
  logic [5:0]  pend_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  reg_file_mp dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr0_en_i   (wr0_en_i),
    .wr0_addr_i (wr0_addr_i),
    .wr0_data_i (wr0_data_i),
    .wr1_en_i   (wr1_en_i),
    .wr1_addr_i (wr1_addr_i),
    .wr1_data_i (wr1_data_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .flush_i    (flush_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_pend_o  (rd_pend_o),
    .pend_cnt_o (pend_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rdat(input int k);
    return 64'(rd_data_o[k*32 +: 32]);
  endfunction

  function automatic logic [63:0] rpnd(input int k);
    return 64'(rd_pend_o[k]);
  endfunction

  task automatic idle();
    wr0_en_i = 1'b0; wr0_addr_i = '0; wr0_data_i = '0;
    wr1_en_i = 1'b0; wr1_addr_i = '0; wr1_data_i = '0;
    rsv_en_i = 1'b0; rsv_addr_i = '0; flush_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr_i = {a1, a0};
    #1;
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    rd_addr_i = '0;
    step(); step();

    // reset overrides a write
    wr0_en_i = 1'b1; wr0_addr_i = 5'd3; wr0_data_i = 32'd5;
    step();
    rst_i = 1'b1; idle();
    rd(5'd3, 5'd0);
    check("rst_r3", rdat(0), 64'd0);
    check("rst_r3_pend", rpnd(0), 64'd0);
    check("rst_cnt", 64'(pend_cnt_o), 64'd0);

    // no dead cycle after reset release
    wr0_en_i = 1'b1; wr0_addr_i = 5'd3; wr0_data_i = 32'h33;
    step(); idle(); rd(5'd3, 5'd0);
    check("post_rst_wr", rdat(0), 64'h33);

    // dual write to same address: port 1 wins
    wr0_en_i = 1'b1; wr0_addr_i = 5'd4; wr0_data_i = 32'h11;
    wr1_en_i = 1'b1; wr1_addr_i = 5'd4; wr1_data_i = 32'h22;
    rd(5'd4, 5'd0);
    check("dual_same_cyc", rdat(0), BYP ? 64'h22 : 64'h0);
    step(); idle(); rd(5'd4, 5'd0);
    check("dual_r4", rdat(0), 64'h22);

    // bypass behaviour on port 0, port 1 reads stored r4
    wr0_en_i = 1'b1; wr0_addr_i = 5'd7; wr0_data_i = 32'hABCD;
    rd(5'd7, 5'd4);
    check("byp_same_cyc", rdat(0), BYP ? 64'hABCD : 64'h0);
    check("byp_port1_r4", rdat(1), 64'h22);
    step(); idle(); rd(5'd7, 5'd4);
    check("byp_next_cyc", rdat(0), 64'hABCD);

    // scoreboard
    rsv_en_i = 1'b1; rsv_addr_i = 5'd5; step();
    rsv_addr_i = 5'd9; step(); idle();
    rd(5'd5, 5'd9);
    check("sb_cnt2", 64'(pend_cnt_o), 64'd2);
    check("sb_p5", rpnd(0), 64'd1);
    check("sb_p9", rpnd(1), 64'd1);
    wr1_en_i = 1'b1; wr1_addr_i = 5'd5; wr1_data_i = 32'h55;
    rd(5'd5, 5'd9);
    check("sb_wr5_same_pend", rpnd(0), BYP ? 64'd0 : 64'd1);
    step(); idle(); rd(5'd5, 5'd9);
    check("sb_wr5_pend", rpnd(0), 64'd0);
    check("sb_wr5_data", rdat(0), 64'h55);
    check("sb_cnt1", 64'(pend_cnt_o), 64'd1);
    rsv_en_i = 1'b1; rsv_addr_i = 5'd9;
    wr0_en_i = 1'b1; wr0_addr_i = 5'd9; wr0_data_i = 32'h99;
    rd(5'd5, 5'd9);
    check("sb_rsvwr_same_pend", rpnd(1), 64'd1);
    step(); idle(); rd(5'd5, 5'd9);
    check("sb_rsvwr_pend", rpnd(1), 64'd1);
    check("sb_rsvwr_data", rdat(1), 64'h99);
    check("sb_rsvwr_cnt", 64'(pend_cnt_o), 64'd1);
    rsv_en_i = 1'b1; rsv_addr_i = 5'd9; step(); idle();
    check("sb_rersv_cnt", 64'(pend_cnt_o), 64'd1);

    // flush beats reserve; write in the same cycle still lands
    rsv_en_i = 1'b1; rsv_addr_i = 5'd2; flush_i = 1'b1;
    wr0_en_i = 1'b1; wr0_addr_i = 5'd6; wr0_data_i = 32'h66;
    step(); idle(); rd(5'd2, 5'd9);
    check("flush_cnt", 64'(pend_cnt_o), 64'd0);
    check("flush_p2", rpnd(0), 64'd0);
    check("flush_p9", rpnd(1), 64'd0);
    rd(5'd6, 5'd9);
    check("flush_wr6", rdat(0), 64'h66);
    check("flush_keeps_r9", rdat(1), 64'h99);

    // zero register ignores writes and reserves, bypass included
    wr0_en_i = 1'b1; wr0_addr_i = 5'd0; wr0_data_i = 32'hFF;
    wr1_en_i = 1'b1; wr1_addr_i = 5'd0; wr1_data_i = 32'hEE;
    rsv_en_i = 1'b1; rsv_addr_i = 5'd0;
    rd(5'd0, 5'd0);
    check("z_same_data", rdat(0), 64'd0);
    check("z_same_pend", rpnd(0), 64'd0);
    step(); idle(); rd(5'd0, 5'd0);
    check("z_data", rdat(1), 64'd0);
    check("z_pend", rpnd(1), 64'd0);
    check("z_cnt", 64'(pend_cnt_o), 64'd0);

    // reset mid-operation
    wr0_en_i = 1'b1; wr0_addr_i = 5'd1; wr0_data_i = 32'd9;
    rsv_en_i = 1'b1; rsv_addr_i = 5'd10; step(); idle();
    rsv_en_i = 1'b1; rsv_addr_i = 5'd11; step();
    rsv_addr_i = 5'd12; step(); idle();
    rd(5'd1, 5'd12);
    check("mid_cnt3", 64'(pend_cnt_o), 64'd3);
    check("mid_r1", rdat(0), 64'd9);
    check("mid_p12", rpnd(1), 64'd1);
    rst_i = 1'b0;
    rsv_en_i = 1'b1; rsv_addr_i = 5'd13;
    wr1_en_i = 1'b1; wr1_addr_i = 5'd1; wr1_data_i = 32'd7;
    step(); rst_i = 1'b1; idle();
    rd(5'd1, 5'd12);
    check("mid_rst_r1", rdat(0), 64'd0);
    check("mid_rst_p12", rpnd(1), 64'd0);
    check("mid_rst_cnt", 64'(pend_cnt_o), 64'd0);
    rd(5'd13, 5'd10);
    check("mid_rst_p13", rpnd(0), 64'd0);
    check("mid_rst_p10", rpnd(1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
